// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// Signed ops run unsigned on magnitudes; signs are reapplied in FIX.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, rs_q, rs_d, cnt_q, cnt_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*XLEN-1:0] acc_q, acc_d, mul_acc, prod;
  logic              neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   quo, rem;
  logic              qbit, sgn;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rs_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rs_q    <= rs_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? CALC : IDLE;
      CALC:    state_d = (cnt_q == XLEN'(XLEN - 1)) ? FIX : CALC;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rs_d    = rs_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    sgn     = ~op[0];
    // MSB-first shift-add multiply and restoring divide share the accumulator
    mul_acc = {acc_q[2*XLEN-2:0], 1'b0} + (b_q[XLEN-1] ? {{XLEN{1'b0}}, a_q} : '0);
    trial   = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]} - {1'b0, b_q};
    qbit    = ~trial[XLEN];
    prod    = neg_q ? -acc_q : acc_q;
    quo     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem     = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          rs_d   = rs_data;
          a_d    = (sgn && rs_data[XLEN-1]) ? -rs_data : rs_data;
          b_d    = (sgn && rt_data[XLEN-1]) ? -rt_data : rt_data;
          neg_d  = sgn && (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
          rneg_d = sgn && rs_data[XLEN-1];
          acc_d  = '0;
          cnt_d  = '0;
        end else begin
          hi_d = hi_we ? wdata : hi_q;
          lo_d = lo_we ? wdata : lo_q;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (!op_q[1]) begin
          acc_d = mul_acc;
          b_d   = b_q << 1;
        end else begin
          acc_d = {qbit ? trial[XLEN-1:0] : {acc_q[2*XLEN-2:XLEN], a_q[XLEN-1]},
                   acc_q[XLEN-2:0], qbit};
          a_d   = a_q << 1;
        end
      end
      FIX: begin
        done_d = 1'b1;
        hi_d   = !op_q[1] ? prod[2*XLEN-1:XLEN] : (b_q == '0) ? rs_q : rem;
        lo_d   = !op_q[1] ? prod[XLEN-1:0] : (b_q == '0) ? '1 : quo;
      end
      default: ;
    endcase
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the MIPS datapath with the architectural HI/LO registers. It consumes the register file's two read operands for MULT/MULTU/DIV/DIVU, and its HI/LO outputs feed the writeback mux so MFHI/MFLO results return to the register file's write port. One operation is in flight at a time. The control unit stalls on `busy`.

## Interface
- `XLEN`, 32: operand width; HI and LO are each `XLEN` bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_b` input 1: asynchronous, active-low reset.
- `start` input 1: launch the operation in `op` with `rs_data`/`rt_data`; sampled only in IDLE.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data` input XLEN: multiplicand or dividend; latched at start.
- `rt_data` input XLEN: multiplier or divisor; latched at start.
- `hi_we` input 1: MTHI; writes `wdata` to HI.
- `lo_we` input 1: MTLO; writes `wdata` to LO.
- `wdata` input XLEN: MTHI/MTLO data.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse when HI/LO take a new result.
- `hi` output XLEN: HI register.
- `lo` output XLEN: LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE -> CALC on `start`:
  - Latch operands. For signed ops, latch magnitudes and record result signs.
  - Clear the XLEN-bit count and the 2*XLEN accumulator.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, unsigned on magnitudes.
- CALC, divide: restoring, one quotient bit per cycle, unsigned on magnitudes.
- CALC -> FIX after exactly XLEN cycles.
- FIX -> IDLE on the next edge. On that edge:
  - Signed MULT: 2*XLEN product negated if operand signs differ; HI = upper half, LO = lower half.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed DIV: quotient truncates toward zero (negated if signs differ); remainder takes the sign of the dividend.
  - `done` = 1 for this cycle.
- Divide by zero (DIV or DIVU): HI = `rs_data` as latched, LO = all ones. Same latency, no trap.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.
- `start` while busy: ignored; the current operation is unaffected.
- `hi_we`/`lo_we` while busy: ignored.
- `hi_we`/`lo_we` in IDLE: write on that edge.
- `start` and `hi_we`/`lo_we` in the same IDLE cycle: `start` wins, the write is dropped.
- `hi_we` and `lo_we` together: both registers are written with `wdata`.
- Operand inputs are don't-care after the start edge.
- `op` value at start selects the algorithm; `op` is don't-care afterwards.

## Timing
- Reset (async, `rst_b` = 0): state IDLE; HI = 0, LO = 0, `busy` = 0, `done` = 0; accumulator and count cleared.
- Reset asserted mid-operation aborts it immediately. No `done` is produced.
- Start accepted at edge E0. `busy` = 1 from after E0 until edge E(XLEN+1).
- CALC occupies edges E1..E(XLEN). FIX is the cycle after E(XLEN).
- HI/LO update and `done` rise at edge E(XLEN+1), i.e. E33 for XLEN = 32.
- `busy` falls at that same edge. Latency is XLEN+1 cycles from start to result.
- A new `start` is accepted in the cycle `done` is high (state is IDLE); back-to-back throughput is one op per XLEN+2 cycles.
- `hi`/`lo` are register outputs with no combinational path from inputs. MFHI/MFLO read them directly.
- MTHI/MTLO: new value is visible the cycle after the write edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> at E33: HI = 0xFFFFFFFE, LO = 0x00000001, `done` pulses once, `busy` high E1..E32.
- MULT 0xFFFFFFFD (-3) × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Then DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0 -> HI = 0x00000064, LO = 0xFFFFFFFF at E33. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Start DIVU 7/2, pulse `start` with MULTU 3×3 and `lo_we` with 0x1234 at E5 -> final HI = 1, LO = 3, only one `done`.
- MULTU 5×5, deassert `rst_b` at E10 -> immediately HI = LO = 0, `busy` = 0. After release, MULTU 5×5 -> LO = 25, HI = 0.
- IDLE: `hi_we` with 0xCAFEBABE -> next cycle HI = 0xCAFEBABE. Then `start` MULTU 2×3 with `lo_we` 0xDEAD in the same cycle -> LO = 6 after `done`; 0xDEAD never appears on `lo`.
